microcode_bootstrapper: RTL and testbench

Loads the microcode store at power-up by streaming bytes from an external byte source (boot ROM reader or serial receiver) into the microcode SRAM bootstrap write port. Holds the CPU in reset while loading, then releases it. Drives the bootstrap bus consumed by the control logic: BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_N_WE and N_BOOTED. Guarantees BOOTSTRAP_N_WE is never low once N_BOOTED is low.

---
 rtl/microcode_bootstrapper.sv | 121 ++++++++++++
 tb/tb_microcode_bootstrapper.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_bootstrapper.sv
// microcode_bootstrapper: streams DEPTH bytes into the microcode SRAM
// bootstrap port, pulses the write strobe once per byte, then releases
// the CPU from reset. Optional checksum stage: BOOTSTRAP_CHECKSUM_EN.
module microcode_bootstrapper #(
   parameter int DEPTH = 4096
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  SRC_DATA,
   input  logic        SRC_VALID,
   output logic        SRC_READY,
   output logic [11:0] BOOTSTRAP_ADDR,
   output logic [7:0]  BOOTSTRAP_DATA,
   output logic        BOOTSTRAP_N_WE,
   output logic        N_BOOTED,
   output logic        CPU_N_RST,
   output logic        BOOT_ERR
);

   typedef enum logic [2:0] {
      IDLE, LOAD, SETUP, STROBE, HOLD, CHECK, DONE, ERROR
   } state_t;

   localparam logic [11:0] LAST = 12'(DEPTH - 1);

   state_t      state;
   state_t      state_nx;
   logic        xfer;
   logic        last;
   logic [11:0] addr_nx;
   logic [7:0]  data_nx;

   // Ready is a pure state decode so the source never sees a glitch.
   assign SRC_READY = (state == LOAD) || (state == CHECK);
   assign xfer      = SRC_VALID && SRC_READY;
   assign last      = (BOOTSTRAP_ADDR == LAST);

`ifdef BOOTSTRAP_CHECKSUM_EN
   logic [7:0] acc;
   logic [7:0] sum;

   assign sum = acc + SRC_DATA;
`endif

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   state_nx = LOAD;
         LOAD:   if (xfer) state_nx = SETUP;
         SETUP:  state_nx = STROBE;
         STROBE: state_nx = HOLD;
         HOLD: begin
            if (!last)
               state_nx = LOAD;
            else
`ifdef BOOTSTRAP_CHECKSUM_EN
               state_nx = CHECK;
`else
               state_nx = DONE;
`endif
         end
`ifdef BOOTSTRAP_CHECKSUM_EN
         CHECK: begin
            if (xfer)
               state_nx = (sum == 8'h00) ? DONE : ERROR;
         end
`endif
         default: state_nx = state;
      endcase
   end

   // Next values of the bootstrap bus
   always_comb begin
      addr_nx = BOOTSTRAP_ADDR;
      data_nx = BOOTSTRAP_DATA;
      if (state == LOAD && SRC_VALID)
         data_nx = SRC_DATA;
      if (state == HOLD && !last)
         addr_nx = BOOTSTRAP_ADDR + 12'd1;
   end

   // Registered outputs follow the state being entered
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         BOOTSTRAP_ADDR <= 12'h000;
         BOOTSTRAP_DATA <= 8'h00;
         BOOTSTRAP_N_WE <= 1'b1;
         N_BOOTED       <= 1'b1;
         CPU_N_RST      <= 1'b0;
      end else begin
         BOOTSTRAP_ADDR <= addr_nx;
         BOOTSTRAP_DATA <= data_nx;
         BOOTSTRAP_N_WE <= (state_nx != STROBE);
         N_BOOTED       <= (state_nx != DONE);
         CPU_N_RST      <= (state_nx == DONE);
      end
   end

`ifdef BOOTSTRAP_CHECKSUM_EN
   // Running byte sum and sticky error flag
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc      <= 8'h00;
         BOOT_ERR <= 1'b0;
      end else begin
         if (xfer) acc <= sum;
         BOOT_ERR <= (state_nx == ERROR);
      end
   end
`else
   assign BOOT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_bootstrapper.sv
// tb_microcode_bootstrapper: scoreboard bench for microcode_bootstrapper,
// small instance (DEPTH=4) for scenarios, large instance for full depth.
module tb_microcode_bootstrapper;

`ifdef BOOTSTRAP_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  src_data = 8'h00;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic [11:0] addr;
   logic [7:0]  data;
   logic        n_we;
   logic        n_booted;
   logic        cpu_n_rst;
   logic        boot_err;

   logic        b_rst = 1'b1;
   logic [7:0]  b_src = 8'h00;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [11:0] b_addr;
   logic [7:0]  b_data;
   logic        b_n_we;
   logic        b_n_booted;
   logic        b_cpu_n_rst;
   logic        b_err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int b_cyc = 0;
   int n_wr = 0;
   int first_wr = -1;
   int b_n_wr = 0;
   logic [11:0] b_last = 12'h000;

   logic [19:0] exp_q[$];
   logic [19:0] big_q[$];
   logic [19:0] e;
   logic [19:0] be;
   logic [11:0] prev_addr = 12'h000;
   logic [7:0]  prev_data = 8'h00;
   logic [11:0] hold_addr = 12'h000;
   logic [7:0]  hold_data = 8'h00;
   bit          after_wr = 1'b0;

   microcode_bootstrapper #(.DEPTH(4)) dut (
      .CLK(clk), .RST(rst),
      .SRC_DATA(src_data), .SRC_VALID(src_valid), .SRC_READY(src_ready),
      .BOOTSTRAP_ADDR(addr), .BOOTSTRAP_DATA(data),
      .BOOTSTRAP_N_WE(n_we), .N_BOOTED(n_booted),
      .CPU_N_RST(cpu_n_rst), .BOOT_ERR(boot_err)
   );

   microcode_bootstrapper #(.DEPTH(4096)) dut_big (
      .CLK(clk), .RST(b_rst),
      .SRC_DATA(b_src), .SRC_VALID(b_valid), .SRC_READY(b_ready),
      .BOOTSTRAP_ADDR(b_addr), .BOOTSTRAP_DATA(b_data),
      .BOOTSTRAP_N_WE(b_n_we), .N_BOOTED(b_n_booted),
      .CPU_N_RST(b_cpu_n_rst), .BOOT_ERR(b_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
      if (b_rst) b_cyc <= 0;
      else       b_cyc <= b_cyc + 1;
   end

   // SRAM write scoreboard, small instance
   always @(negedge clk) begin
      if (rst) begin
         after_wr = 1'b0;
      end else begin
         if (after_wr) begin
            n_cmp++;
            if ({addr, data} !== {hold_addr, hold_data}) begin
               n_bad++;
               $display("FAIL hold_stable: got %h/%h need %h/%h",
                        addr, data, hold_addr, hold_data);
            end
            after_wr = 1'b0;
         end
         if (!n_we) begin
            if (n_wr == 0) first_wr = cyc;
            n_wr++;
            n_cmp++;
            if ({addr, data} !== {prev_addr, prev_data}) begin
               n_bad++;
               $display("FAIL setup_stable: got %h/%h need %h/%h",
                        addr, data, prev_addr, prev_data);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write: got %h/%h need none",
                        addr, data);
            end else begin
               e = exp_q.pop_front();
               if ({addr, data} !== e) begin
                  n_bad++;
                  $display("FAIL write: got %h/%h need %h/%h",
                           addr, data, e[19:8], e[7:0]);
               end
            end
            n_cmp++;
            if (n_booted !== 1'b1) begin
               n_bad++;
               $display("FAIL booted_in_we: got %b need 1", n_booted);
            end
            after_wr  = 1'b1;
            hold_addr = addr;
            hold_data = data;
         end
      end
      prev_addr = addr;
      prev_data = data;
   end

   // SRAM write scoreboard, full-depth instance
   always @(negedge clk) begin
      if (!b_rst && !b_n_we) begin
         b_n_wr++;
         b_last = b_addr;
         n_cmp++;
         if (big_q.size() == 0) begin
            n_bad++;
            $display("FAIL big_unexpected: got %h/%h need none",
                     b_addr, b_data);
         end else begin
            be = big_q.pop_front();
            if ({b_addr, b_data} !== be) begin
               n_bad++;
               $display("FAIL big_write: got %h/%h need %h/%h",
                        b_addr, b_data, be[19:8], be[7:0]);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      src_valid = 1'b0;
      src_data  = 8'h00;
      repeat (2) @(negedge clk);
      exp_q.delete();
      n_wr     = 0;
      first_wr = -1;
      rst      = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int k,
                       input bit toggle, input bit wr, output bit ok);
      ok = 1'b0;
      src_data = b;
      for (int t = 0; t < 40 && !ok; t++) begin
         src_valid = toggle ? ~src_valid : 1'b1;
         if (src_valid && src_ready) begin
            ok = 1'b1;
            if (wr) exp_q.push_back({12'(k), b});
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: byte %0d got no ready need ready", k);
      end
   endtask

   task automatic wait_boot();
      for (int t = 0; t < 40 && n_booted && !boot_err; t++) begin
         n_cmp++;
         if (cpu_n_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL early_cpu_rst: got %b need 0", cpu_n_rst);
         end
         @(negedge clk);
      end
      if (n_booted && !boot_err) begin
         n_cmp++;
         n_bad++;
         $display("FAIL boot_timeout: got n_booted=1 need 0");
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      src_valid = 1'b1;
      src_data  = 8'hA5;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({addr, data, n_we, n_booted, cpu_n_rst, boot_err, src_ready}
          !== {12'h000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h %h %b%b%b%b%b need 000 00 11000",
                  addr, data, n_we, n_booted, cpu_n_rst, boot_err, src_ready);
      end
      src_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({src_ready, n_we, addr} !== {1'b1, 1'b1, 12'h000}) begin
         n_bad++;
         $display("FAIL first_load: got %b %b %h need 1 1 000",
                  src_ready, n_we, addr);
      end
   endtask

   task automatic load4(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3,
                        input logic [7:0] ck, input bit toggle);
      logic [7:0] v[4];
      bit ok;
      v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3;
      for (int k = 0; k < 4; k++) send(v[k], k, toggle, 1'b1, ok);
      if (CK != 0) send(ck, 0, toggle, 1'b0, ok);
   endtask

   task automatic test_continuous();
      do_reset();
      load4(8'h11, 8'h22, 8'h33, 8'h44, 8'h56, 1'b0);
      wait_boot();
      n_cmp++;
      if (cyc !== 17 + CK) begin
         n_bad++;
         $display("FAIL boot_cycle: got %0d need %0d", cyc, 17 + CK);
      end
      n_cmp++;
      if ({n_booted, cpu_n_rst, boot_err} !== 3'b010) begin
         n_bad++;
         $display("FAIL done_flags: got %b%b%b need 010",
                  n_booted, cpu_n_rst, boot_err);
      end
      n_cmp++;
      if (n_wr !== 4 || exp_q.size() !== 0) begin
         n_bad++;
         $display("FAIL write_count: got %0d left %0d need 4 left 0",
                  n_wr, exp_q.size());
      end
      n_cmp++;
      if (first_wr !== 3) begin
         n_bad++;
         $display("FAIL first_strobe: got %0d need 3", first_wr);
      end
   endtask

   task automatic test_after_done();
      for (int i = 0; i < 10; i++) begin
         src_valid = 1'b1;
         src_data  = 8'($urandom);
         @(negedge clk);
         n_cmp++;
         if ({src_ready, n_we, addr, n_booted} !== {1'b0, 1'b1, 12'h003, 1'b0})
         begin
            n_bad++;
            $display("FAIL after_done: got %b %b %h %b need 0 1 003 0",
                     src_ready, n_we, addr, n_booted);
         end
      end
      src_valid = 1'b0;
   endtask

   task automatic test_toggle();
      do_reset();
      load4(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h16, 1'b1);
      wait_boot();
      n_cmp++;
      if ({n_booted, cpu_n_rst, n_wr} !== {1'b0, 1'b1, 32'd4}) begin
         n_bad++;
         $display("FAIL toggle_done: got %b %b %0d need 0 1 4",
                  n_booted, cpu_n_rst, n_wr);
      end
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_bad++;
         $display("FAIL toggle_left: got %0d need 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit hit;
      do_reset();
      send(8'h5A, 0, 1'b0, 1'b1, ok);
      send(8'h6B, 1, 1'b0, 1'b1, ok);
      send(8'h7C, 2, 1'b0, 1'b1, ok);
      src_valid = 1'b0;
      hit = 1'b0;
      for (int t = 0; t < 10 && !hit; t++) begin
         if (!n_we && addr == 12'h002) hit = 1'b1;
         else @(negedge clk);
      end
      n_cmp++;
      if (!hit) begin
         n_bad++;
         $display("FAIL strobe2_seen: got none need strobe at 002");
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({n_we, addr, data, src_ready} !== {1'b1, 12'h000, 8'h00, 1'b0}) begin
         n_bad++;
         $display("FAIL async_reset: got %b %h %h %b need 1 000 00 0",
                  n_we, addr, data, src_ready);
      end
      do_reset();
      load4(8'h11, 8'h22, 8'h33, 8'h44, 8'h56, 1'b0);
      wait_boot();
      n_cmp++;
      if ({n_booted, n_wr, exp_q.size()} !== {1'b0, 32'd4, 32'd0}) begin
         n_bad++;
         $display("FAIL reload: got %b %0d %0d need 0 4 0",
                  n_booted, n_wr, exp_q.size());
      end
   endtask

`ifdef BOOTSTRAP_CHECKSUM_EN
   task automatic test_checksum();
      do_reset();
      load4(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 1'b0);
      wait_boot();
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({boot_err, n_booted, cpu_n_rst, src_ready, n_we}
          !== 5'b11001) begin
         n_bad++;
         $display("FAIL ck_error: got %b%b%b%b%b need 11001",
                  boot_err, n_booted, cpu_n_rst, src_ready, n_we);
      end
      do_reset();
      load4(8'h01, 8'h02, 8'h03, 8'h04, 8'hF6, 1'b0);
      wait_boot();
      n_cmp++;
      if ({boot_err, n_booted, cpu_n_rst} !== 3'b001) begin
         n_bad++;
         $display("FAIL ck_good: got %b%b%b need 001",
                  boot_err, n_booted, cpu_n_rst);
      end
   endtask
`endif

   task automatic test_full_depth();
      bit ok;
      logic [7:0] s;
      logic [7:0] v;
      s = 8'h00;
      @(negedge clk);
      b_rst = 1'b1;
      repeat (2) @(negedge clk);
      big_q.delete();
      b_n_wr = 0;
      b_rst  = 1'b0;
      for (int k = 0; k < 4096 + CK; k++) begin
         v = (k < 4096) ? 8'(k * 7 + 3) : 8'(-s);
         s = s + v;
         b_src   = v;
         b_valid = 1'b1;
         ok = 1'b0;
         for (int t = 0; t < 20 && !ok; t++) begin
            if (b_ready) begin
               ok = 1'b1;
               if (k < 4096) big_q.push_back({12'(k), v});
            end
            @(negedge clk);
         end
         if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL big_timeout: byte %0d got no ready need ready", k);
            break;
         end
      end
      for (int t = 0; t < 20 && b_n_booted; t++) @(negedge clk);
      n_cmp++;
      if (b_cyc !== 16385 + CK || b_n_booted !== 1'b0) begin
         n_bad++;
         $display("FAIL big_boot: got cyc %0d nb %b need %0d 0",
                  b_cyc, b_n_booted, 16385 + CK);
      end
      n_cmp++;
      if ({b_n_wr, b_last, big_q.size()} !== {32'd4096, 12'hFFF, 32'd0}) begin
         n_bad++;
         $display("FAIL big_writes: got %0d %h %0d need 4096 fff 0",
                  b_n_wr, b_last, big_q.size());
      end
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({b_addr, b_ready, b_cpu_n_rst, b_n_wr} !==
          {12'hFFF, 1'b0, 1'b1, 32'd4096}) begin
         n_bad++;
         $display("FAIL big_hold: got %h %b %b %0d need fff 0 1 4096",
                  b_addr, b_ready, b_cpu_n_rst, b_n_wr);
      end
      b_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish need finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_continuous();
      test_after_done();
      test_toggle();
      test_reset_mid();
`ifdef BOOTSTRAP_CHECKSUM_EN
      test_checksum();
`endif
      test_full_depth();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
